// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: bus widths, reset PC,
// fetch FSM encoding and the prefetch entry layout.
package instruction_fetch_unit_pkg;

  localparam int ADDR_W     = 16;
  localparam int DATA_W     = 16;
  localparam int FIFO_DEPTH = 4;

  localparam logic [ADDR_W-1:0] RESET_PC = 16'h0000;

  localparam logic [1:0] ST_REQ     = 2'd0;
  localparam logic [1:0] ST_WAIT    = 2'd1;
  localparam logic [1:0] ST_DISCARD = 2'd2;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] data;
  } fetch_entry_t;

  // Occupancy counter must be able to hold the value DEPTH itself.
  function automatic int level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Bundles the instruction-memory and core-side handshakes of the fetch unit.
// master = fetch unit, slave = memory/core environment.
interface instruction_fetch_unit_if #(
  parameter int FIFO_DEPTH = instruction_fetch_unit_pkg::FIFO_DEPTH
);
  import instruction_fetch_unit_pkg::*;

  localparam int LEVEL_W = level_width(FIFO_DEPTH);

  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_gnt;
  logic              imem_rvalid;
  logic [DATA_W-1:0] imem_rdata;

  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;

  logic               instr_valid;
  logic [DATA_W-1:0]  instruction;
  logic [ADDR_W-1:0]  instr_pc;
  logic               instr_ready;
  logic [LEVEL_W-1:0] fifo_level;

  modport master (
    output imem_req, imem_addr, instr_valid, instruction, instr_pc, fifo_level,
    input  imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instruction, instr_pc, fifo_level,
    output imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, instr_ready
  );

endinterface

// File: rtl/instruction_fetch_unit_prefetch_fifo.sv
// Synchronous prefetch FIFO of {pc, data} entries with flush and occupancy level.
// The head is read straight from storage registers, so it never depends on entry_i.
module prefetch_fifo
  import instruction_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push_i,
  input  fetch_entry_t           entry_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  output fetch_entry_t           head_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [LVL_W-1:0] level_q;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (level_q == '0);
  assign full    = (level_q == LVL_W'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  // When full, a push is only accepted alongside a pop; it reuses the slot being vacated.
  assign do_push = push_i && (!full || do_pop);
  assign head_o  = mem_q[rd_ptr_q];
  assign level_o = level_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= entry_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      level_q <= level_q + LVL_W'(do_push) - LVL_W'(do_pop);
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC and the req/gnt/rvalid fetch FSM, issues reads under a
// credit limit and feeds the core from the prefetch FIFO; redirects flush and discard.
module instruction_fetch_unit #(
  parameter int FIFO_DEPTH = instruction_fetch_unit_pkg::FIFO_DEPTH,
  parameter logic [instruction_fetch_unit_pkg::ADDR_W-1:0] RESET_PC =
    instruction_fetch_unit_pkg::RESET_PC
) (
  input logic                      clk,
  input logic                      reset,
  instruction_fetch_unit_if.master bus
);
  import instruction_fetch_unit_pkg::*;

  localparam int LEVEL_W = level_width(FIFO_DEPTH);

  logic [1:0]         state_q;
  logic [1:0]         state_d;
  logic [ADDR_W-1:0]  pc_q;
  logic [ADDR_W-1:0]  pc_d;
  logic [ADDR_W-1:0]  req_pc_q;
  logic [ADDR_W-1:0]  req_pc_d;
  logic               credit;
  logic               req_raw;
  logic               granted;
  logic               push;
  logic               pop;
  logic               fifo_empty;
  logic [LEVEL_W-1:0] level;
  fetch_entry_t       push_entry;
  fetch_entry_t       head;

  // Anything not in REQ holds the single outstanding read, which already owns a FIFO slot.
  assign credit  = (int'(level) + int'(state_q != ST_REQ)) < FIFO_DEPTH;
  assign req_raw = (state_q == ST_REQ) && credit;
  assign granted = req_raw && bus.imem_gnt;

  assign bus.imem_req    = req_raw && !bus.redirect_valid && !reset;
  assign bus.imem_addr   = pc_q;
  assign bus.instr_valid = !fifo_empty && !bus.redirect_valid;
  assign bus.instruction = head.data;
  assign bus.instr_pc    = head.pc;
  assign bus.fifo_level  = level;

  assign pop        = bus.instr_valid && bus.instr_ready;
  assign push       = (state_q == ST_WAIT) && bus.imem_rvalid && !bus.redirect_valid;
  assign push_entry = '{pc: req_pc_q, data: bus.imem_rdata};

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    case (state_q)
      ST_REQ: begin
        if (granted) begin
          if (bus.redirect_valid) begin
            state_d = ST_DISCARD;
          end else begin
            state_d  = ST_WAIT;
            pc_d     = pc_q + 1'b1;
            req_pc_d = pc_q;
          end
        end
      end
      ST_WAIT: begin
        if (bus.imem_rvalid) begin
          state_d = ST_REQ;
        end else if (bus.redirect_valid) begin
          state_d = ST_DISCARD;
        end
      end
      ST_DISCARD: begin
        if (bus.imem_rvalid) begin
          state_d = ST_REQ;
        end
      end
      default: state_d = ST_REQ;
    endcase
    if (bus.redirect_valid) begin
      pc_d = bus.redirect_pc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_REQ;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
    end
  end

  prefetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_prefetch_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .entry_i (push_entry),
    .pop_i   (pop),
    .flush_i (bus.redirect_valid),
    .head_o  (head),
    .empty_o (fifo_empty),
    .level_o (level)
  );

  a_rvalid_has_outstanding: assert property (
    @(posedge clk) disable iff (reset) bus.imem_rvalid |-> (state_q != ST_REQ)
  );

  a_req_held_until_gnt: assert property (
    @(posedge clk) disable iff (reset)
    (bus.imem_req && !bus.imem_gnt) |=>
      (bus.redirect_valid || (bus.imem_req && $stable(bus.imem_addr)))
  );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: a cycle table for the steady
// fetch stream plus directed sequences for backpressure, redirects, wrap and reset.
module tb_instruction_fetch_unit;
  import instruction_fetch_unit_pkg::*;

  localparam int DEPTH = 4;
  localparam int LVL_W = $clog2(DEPTH) + 1;

  typedef struct {
    logic              gnt;
    logic              ready;
    logic              expReq;
    logic [ADDR_W-1:0] expAddr;
    logic              expValid;
    logic [ADDR_W-1:0] expPc;
    logic [LVL_W-1:0]  expLevel;
  } vec_t;

  logic clk;
  logic reset;
  int   checksTotal  = 0;
  int   checksPassed = 0;
  int   respLatency  = 1;

  logic [ADDR_W-1:0] xferPc[$];
  logic [DATA_W-1:0] xferData[$];
  vec_t              vecs[9];

  instruction_fetch_unit_if #(.FIFO_DEPTH(DEPTH)) bus();

  instruction_fetch_unit #(
    .FIFO_DEPTH (DEPTH),
    .RESET_PC   (16'h0000)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [DATA_W-1:0] memWord(input logic [ADDR_W-1:0] a);
    return a ^ 16'h5A3C;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checksTotal++;
    if (actual === expected) checksPassed++;
    else $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
  endtask

  task automatic applyStimulus(input logic gnt, input logic ready, input logic redir,
                               input logic [ADDR_W-1:0] redirPc);
    bus.imem_gnt       = gnt;
    bus.instr_ready    = ready;
    bus.redirect_valid = redir;
    bus.redirect_pc    = redirPc;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Returns at posedge+1 with reset still high; caller drops reset to start cycle C0.
  task automatic doReset();
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
    reset = 1'b1;
    nextCycle();
    nextCycle();
    xferPc.delete();
    xferData.delete();
  endtask

  task automatic waitXfers(input int n, input int budget, input string name);
    int c;
    c = 0;
    while (xferPc.size() < n && c < budget) begin
      nextCycle();
      c++;
    end
    if (xferPc.size() < n) checkOutput({name, "_timeout"}, 32'(xferPc.size()), 32'(n));
  endtask

  task automatic checkXfer(input int idx, input logic [ADDR_W-1:0] pc, input string name);
    if (xferPc.size() > idx) begin
      checkOutput({name, "_pc"}, 32'(xferPc[idx]), 32'(pc));
      checkOutput({name, "_data"}, 32'(xferData[idx]), 32'(memWord(pc)));
    end
  endtask

  // Instruction memory: answers each accepted request after respLatency cycles.
  initial begin : memResponder
    logic [ADDR_W-1:0] a;
    logic              killed;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    forever begin
      @(negedge clk);
      if (!reset && bus.imem_req && bus.imem_gnt) begin
        a      = bus.imem_addr;
        killed = 1'b0;
        for (int k = 0; k < respLatency; k++) begin
          @(posedge clk);
          if (reset) killed = 1'b1;
        end
        #1;
        if (!reset && !killed) begin
          bus.imem_rvalid = 1'b1;
          bus.imem_rdata  = memWord(a);
        end
        @(posedge clk);
        #1;
        bus.imem_rvalid = 1'b0;
      end
    end
  end

  initial begin : xferMonitor
    forever begin
      @(negedge clk);
      if (!reset && bus.instr_valid && bus.instr_ready) begin
        xferPc.push_back(bus.instr_pc);
        xferData.push_back(bus.instruction);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : mainTest
    logic [LVL_W-1:0] peak;
    logic             found;

    vecs[0] = '{1'b1, 1'b1, 1'b1, 16'h0000, 1'b0, 16'h0000, 3'd0};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 16'h0001, 1'b0, 16'h0000, 3'd0};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 16'h0001, 1'b1, 16'h0000, 3'd1};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 16'h0002, 1'b0, 16'h0000, 3'd0};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 16'h0002, 1'b1, 16'h0001, 3'd1};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 16'h0003, 1'b0, 16'h0000, 3'd0};
    vecs[6] = '{1'b1, 1'b1, 1'b1, 16'h0003, 1'b1, 16'h0002, 3'd1};
    vecs[7] = '{1'b1, 1'b1, 1'b0, 16'h0004, 1'b0, 16'h0000, 3'd0};
    vecs[8] = '{1'b1, 1'b1, 1'b1, 16'h0004, 1'b1, 16'h0003, 3'd1};

    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
    nextCycle();
    @(negedge clk);
    checkOutput("rst_req",   32'(bus.imem_req),    32'd0);
    checkOutput("rst_addr",  32'(bus.imem_addr),   32'd0);
    checkOutput("rst_valid", 32'(bus.instr_valid), 32'd0);
    checkOutput("rst_level", 32'(bus.fifo_level),  32'd0);
    checkOutput("rst_instr", 32'(bus.instruction), 32'd0);
    checkOutput("rst_pc",    32'(bus.instr_pc),    32'd0);
    nextCycle();

    $display("[TB] test 1: steady stream, gnt=1 ready=1");
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].gnt, vecs[i].ready, 1'b0, 16'h0000);
      if (i == 0) reset = 1'b0;
      @(negedge clk);
      checkOutput($sformatf("t1_c%0d_req", i),   32'(bus.imem_req),    32'(vecs[i].expReq));
      checkOutput($sformatf("t1_c%0d_addr", i),  32'(bus.imem_addr),   32'(vecs[i].expAddr));
      checkOutput($sformatf("t1_c%0d_valid", i), 32'(bus.instr_valid), 32'(vecs[i].expValid));
      checkOutput($sformatf("t1_c%0d_level", i), 32'(bus.fifo_level),  32'(vecs[i].expLevel));
      if (vecs[i].expValid) begin
        checkOutput($sformatf("t1_c%0d_ipc", i),   32'(bus.instr_pc),    32'(vecs[i].expPc));
        checkOutput($sformatf("t1_c%0d_instr", i), 32'(bus.instruction), 32'(memWord(vecs[i].expPc)));
      end
      nextCycle();
    end

    $display("[TB] test 2: backpressure fills the prefetch buffer");
    respLatency = 1;
    doReset();
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
    reset = 1'b0;
    peak = '0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.fifo_level > peak) peak = bus.fifo_level;
      nextCycle();
    end
    @(negedge clk);
    checkOutput("t2_peak",  32'(peak),            32'd4);
    checkOutput("t2_level", 32'(bus.fifo_level),  32'd4);
    checkOutput("t2_req",   32'(bus.imem_req),    32'd0);
    checkOutput("t2_valid", 32'(bus.instr_valid), 32'd1);
    checkOutput("t2_addr",  32'(bus.imem_addr),   32'h4);
    nextCycle();
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
    waitXfers(6, 40, "t2");
    for (int i = 0; i < 6; i++) checkXfer(i, ADDR_W'(i), $sformatf("t2_x%0d", i));

    $display("[TB] test 3: redirect while a read is in flight");
    respLatency = 3;
    doReset();
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
    reset = 1'b0;
    nextCycle();
    applyStimulus(1'b1, 1'b1, 1'b1, 16'h0040);
    @(negedge clk);
    checkOutput("t3_req_forced", 32'(bus.imem_req), 32'd0);
    nextCycle();
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
    @(negedge clk);
    checkOutput("t3_discard_req",  32'(bus.imem_req),  32'd0);
    checkOutput("t3_discard_addr", 32'(bus.imem_addr), 32'h40);
    nextCycle();
    nextCycle();
    @(negedge clk);
    checkOutput("t3_level", 32'(bus.fifo_level),  32'd0);
    checkOutput("t3_valid", 32'(bus.instr_valid), 32'd0);
    checkOutput("t3_req",   32'(bus.imem_req),    32'd1);
    checkOutput("t3_addr",  32'(bus.imem_addr),   32'h40);
    nextCycle();
    waitXfers(1, 20, "t3");
    checkXfer(0, 16'h0040, "t3_x0");

    $display("[TB] test 4: redirect against transfer and against rvalid");
    respLatency = 1;
    doReset();
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
    reset = 1'b0;
    nextCycle();
    nextCycle();
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h0080);
    @(negedge clk);
    checkOutput("t4_valid_forced", 32'(bus.instr_valid), 32'd0);
    checkOutput("t4_req_forced",   32'(bus.imem_req),    32'd0);
    nextCycle();
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
    @(negedge clk);
    checkOutput("t4_flush_level", 32'(bus.fifo_level), 32'd0);
    checkOutput("t4_addr80",      32'(bus.imem_addr),  32'h80);
    checkOutput("t4_req80",       32'(bus.imem_req),   32'd1);
    nextCycle();
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h0100);
    @(negedge clk);
    checkOutput("t4_rvalid_seen", 32'(bus.imem_rvalid), 32'd1);
    nextCycle();
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
    @(negedge clk);
    checkOutput("t4_drop_level", 32'(bus.fifo_level),  32'd0);
    checkOutput("t4_drop_valid", 32'(bus.instr_valid), 32'd0);
    checkOutput("t4_addr100",    32'(bus.imem_addr),   32'h100);
    checkOutput("t4_req100",     32'(bus.imem_req),    32'd1);
    checkOutput("t4_no_xfer",    32'(xferPc.size()),   32'd0);
    nextCycle();
    waitXfers(1, 20, "t4");
    checkXfer(0, 16'h0100, "t4_x0");

    $display("[TB] test 5: PC wrap and request hold without grant");
    respLatency = 1;
    doReset();
    applyStimulus(1'b0, 1'b1, 1'b1, 16'hFFFF);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("t5_req_redir", 32'(bus.imem_req), 32'd0);
    nextCycle();
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
    @(negedge clk);
    checkOutput("t5_addr_ffff", 32'(bus.imem_addr), 32'hFFFF);
    checkOutput("t5_req_ffff",  32'(bus.imem_req),  32'd1);
    nextCycle();
    @(negedge clk);
    checkOutput("t5_wrap", 32'(bus.imem_addr), 32'h0);
    nextCycle();
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checkOutput($sformatf("t5_hold%0d_req", c),  32'(bus.imem_req),  32'd1);
      checkOutput($sformatf("t5_hold%0d_addr", c), 32'(bus.imem_addr), 32'h0);
      nextCycle();
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
    waitXfers(2, 20, "t5");
    checkXfer(0, 16'hFFFF, "t5_x0");
    checkXfer(1, 16'h0000, "t5_x1");

    $display("[TB] test 6: reset during an outstanding read");
    respLatency = 2;
    doReset();
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
    reset = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk);
      if (bus.fifo_level == 3'd3 && !bus.imem_req && !bus.imem_rvalid) found = 1'b1;
      else nextCycle();
    end
    checkOutput("t6_reach_wait_l3", 32'(found), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("t6_req",   32'(bus.imem_req),    32'd0);
    checkOutput("t6_addr",  32'(bus.imem_addr),   32'd0);
    checkOutput("t6_valid", 32'(bus.instr_valid), 32'd0);
    checkOutput("t6_level", 32'(bus.fifo_level),  32'd0);
    checkOutput("t6_instr", 32'(bus.instruction), 32'd0);
    checkOutput("t6_ipc",   32'(bus.instr_pc),    32'd0);
    nextCycle();
    nextCycle();
    xferPc.delete();
    xferData.delete();
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("t6_restart_req",  32'(bus.imem_req),  32'd1);
    checkOutput("t6_restart_addr", 32'(bus.imem_addr), 32'h0);
    nextCycle();
    waitXfers(2, 30, "t6");
    checkXfer(0, 16'h0000, "t6_x0");
    checkXfer(1, 16'h0001, "t6_x1");

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
